// File: rtl/mat_pkg.sv
// Shared definitions for the 2x2 matrix multiplier datapath.
// Holds element geometry, the loader state encoding and the packing-order
// helper that both the operand loader and the multiplier use to locate
// element (i,j) inside a packed operand word.
package mat_pkg;

  localparam int ELEM_W = 8;
  localparam int DIM    = 2;
  localparam int N      = DIM * DIM;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // Row-major packing with element (0,0) in the MSBs.
  function automatic int elem_off(input int i, input int j);
    return (N - 1 - (i * DIM + j)) * ELEM_W;
  endfunction

endpackage

// File: rtl/mat_elem_shift.sv
// N-element load register for one matrix operand.
// Ports:
//   clk  - clock
//   clr  - synchronous clear of all elements
//   we   - write enable for the element selected by idx
//   idx  - row-major element index (0 .. N-1)
//   din  - element value
//   dout - packed elements, element 0 in the MSBs
module mat_elem_shift
  import mat_pkg::*;
#(
  parameter int ELEM_W = mat_pkg::ELEM_W,
  parameter int DIM    = mat_pkg::DIM
) (
  input  logic                              clk,
  input  logic                              clr,
  input  logic                              we,
  input  logic [$clog2(DIM*DIM)-1:0]        idx,
  input  logic [ELEM_W-1:0]                 din,
  output logic [DIM*DIM*ELEM_W-1:0]         dout
);

  int off;

  always_comb begin
    off = elem_off(int'(idx) / DIM, int'(idx) % DIM);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      dout <= '0;
    end else if (we) begin
      dout[off +: ELEM_W] <= din;
    end
  end

endmodule

// File: rtl/mat_operand_loader.sv
// Collects a serial byte stream into the packed A and B operand words of the
// 2x2 matrix multiplier and presents them on a valid/ready handshake.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_data/in_valid  - element stream; in_sof marks A[0][0] of a frame
//   in_ready          - loader accepts a byte this cycle
//   out_a/out_b       - packed operands, {x00,x01,x10,x11}, x00 in MSBs
//   out_valid/out_ready - pair handshake
//   frame_err         - one-cycle pulse when a partial frame is dropped
//   frame_cnt         - number of pairs handed off (wraps)
module mat_operand_loader
  import mat_pkg::*;
#(
  parameter int ELEM_W = mat_pkg::ELEM_W,
  parameter int DIM    = mat_pkg::DIM,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ELEM_W-1:0]         in_data,
  input  logic                      in_valid,
  input  logic                      in_sof,
  output logic                      in_ready,
  output logic [DIM*DIM*ELEM_W-1:0] out_a,
  output logic [DIM*DIM*ELEM_W-1:0] out_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      frame_err,
  output logic [CNT_W-1:0]          frame_cnt
);

  localparam int NE    = DIM * DIM;
  localparam int IDX_W = $clog2(NE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NE - 1);

  state_t               state, state_n;
  logic [IDX_W-1:0]     idx, idx_n, a_idx;
  logic                 acc, sof_err, last, load_out, handoff;
  logic                 we_a, we_b;
  logic [NE*ELEM_W-1:0] a_q, b_q;

  assign in_ready  = (state != PRESENT) && !rst;
  assign out_valid = (state == PRESENT);
  assign acc       = in_valid && in_ready;
  assign last      = (idx == IDX_LAST);
  assign handoff   = (state == PRESENT) && out_ready;

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    sof_err  = 1'b0;
    load_out = 1'b0;
    we_a     = 1'b0;
    we_b     = 1'b0;
    a_idx    = idx;
    if (acc) begin
      if (in_sof && !(state == LOAD_A && idx == '0)) begin
        // Resync: this byte restarts the frame as A00.
        sof_err = 1'b1;
        we_a    = 1'b1;
        a_idx   = '0;
        state_n = LOAD_A;
        idx_n   = IDX_W'(1);
      end else begin
        we_a  = (state == LOAD_A);
        we_b  = (state == LOAD_B);
        idx_n = last ? '0 : idx + IDX_W'(1);
        if (last) begin
          state_n  = (state == LOAD_A) ? LOAD_B : PRESENT;
          load_out = (state == LOAD_B);
        end
      end
    end
    if (handoff) begin
      state_n = LOAD_A;
    end
  end

  mat_elem_shift #(.ELEM_W(ELEM_W), .DIM(DIM)) u_a (
    .clk  (clk),
    .clr  (rst),
    .we   (we_a),
    .idx  (a_idx),
    .din  (in_data),
    .dout (a_q)
  );

  mat_elem_shift #(.ELEM_W(ELEM_W), .DIM(DIM)) u_b (
    .clk  (clk),
    .clr  (rst),
    .we   (we_b),
    .idx  (idx),
    .din  (in_data),
    .dout (b_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_A;
      idx       <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      out_a     <= '0;
      out_b     <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      frame_err <= sof_err;
      if (handoff) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      // The last B element lands at offset 0 in the same cycle, so splice
      // the incoming byte in rather than waiting for the register write.
      if (load_out) begin
        out_a <= a_q;
        out_b <= {b_q[NE*ELEM_W-1:ELEM_W], in_data};
      end
    end
  end

endmodule

// File: tb/tb_mat_operand_loader.sv
module tb_mat_operand_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sof;
  logic        out_ready;
  logic        in_ready, out_valid, frame_err;
  logic [31:0] out_a, out_b;
  logic [15:0] frame_cnt;
  logic        in_ready2, out_valid2, frame_err2;
  logic [31:0] out_a2, out_b2;
  logic [1:0]  frame_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mat_operand_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_ready(in_ready), .out_a(out_a), .out_b(out_b),
    .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  mat_operand_loader #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_ready(in_ready2), .out_a(out_a2), .out_b(out_b2),
    .out_valid(out_valid2), .out_ready(out_ready), .frame_err(frame_err2),
    .frame_cnt(frame_cnt2)
  );

  task automatic push(input logic [7:0] d, input logic sof);
    in_data = d; in_sof = sof; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic stream(input logic [7:0] base);
    for (int i = 0; i < 8; i++) push(base + 8'(i), (i == 0));
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    checks++; if (out_a !== 32'h0 || out_b !== 32'h0) begin errors++; $display("FAIL rst_out got=%h/%h want=0/0", out_a, out_b); end
    checks++; if (frame_cnt !== 16'd0 || frame_err !== 1'b0) begin errors++; $display("FAIL rst_cnt_err got=%0d/%b want=0/0", frame_cnt, frame_err); end
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    stream(8'h01);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_valid got=%b/%b want=1/0", out_valid, in_ready); end
    checks++; if (out_a !== 32'h01020304) begin errors++; $display("FAIL basic_out_a got=%h want=01020304", out_a); end
    checks++; if (out_b !== 32'h05060708) begin errors++; $display("FAIL basic_out_b got=%h want=05060708", out_b); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL basic_cnt_before got=%0d want=0", frame_cnt); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_after got=%b/%b want=0/1", out_valid, in_ready); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt got=%0d want=1", frame_cnt); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    stream(8'h01);
    // Junk offered while presenting must be ignored.
    in_valid = 1'b1; in_data = 8'hEE; in_sof = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got=%b/%b want=1/0", k, out_valid, in_ready); end
      checks++; if (out_a !== 32'h01020304 || out_b !== 32'h05060708) begin errors++; $display("FAIL bp_data%0d got=%h/%h want=01020304/05060708", k, out_a, out_b); end
      checks++; if (frame_err !== 1'b0 || frame_cnt !== 16'd1) begin errors++; $display("FAIL bp_ctl%0d got=%b/%0d want=0/1", k, frame_err, frame_cnt); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || frame_cnt !== 16'd2) begin errors++; $display("FAIL bp_handoff got=%b/%0d want=0/2", out_valid, frame_cnt); end
  endtask

  task automatic test_sof_resync;
    out_ready = 1'b1;
    push(8'h11, 1'b1); push(8'h22, 1'b0); push(8'h33, 1'b0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL sof_no_err got=%b want=0", frame_err); end
    push(8'hA0, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL sof_err_pulse got=%b want=1", frame_err); end
    push(8'hA1, 1'b0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL sof_err_one_cycle got=%b want=0", frame_err); end
    for (int i = 2; i < 8; i++) push(8'hA0 + 8'(i), 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sof_valid got=%b want=1", out_valid); end
    checks++; if (out_a !== 32'hA0A1A2A3 || out_b !== 32'hA4A5A6A7) begin errors++; $display("FAIL sof_data got=%h/%h want=A0A1A2A3/A4A5A6A7", out_a, out_b); end
    @(posedge clk); #1;
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL sof_cnt got=%0d want=3", frame_cnt); end
  endtask

  task automatic test_reset_midframe;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h01 + 8'(i), (i == 0));
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got=%b/%b want=0/0", in_ready, out_valid); end
    checks++; if (out_a !== 32'h0 || out_b !== 32'h0) begin errors++; $display("FAIL mid_rst_out got=%h/%h want=0/0", out_a, out_b); end
    checks++; if (frame_cnt !== 16'd0 || frame_cnt2 !== 2'd0) begin errors++; $display("FAIL mid_rst_cnt got=%0d/%0d want=0/0", frame_cnt, frame_cnt2); end
    rst = 1'b0;
    stream(8'h01);
    checks++; if (out_valid !== 1'b1 || out_a !== 32'h01020304 || out_b !== 32'h05060708) begin errors++; $display("FAIL mid_data got=%b %h/%h want=1 01020304/05060708", out_valid, out_a, out_b); end
    @(posedge clk); #1;
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_cnt got=%0d want=1", frame_cnt); end
  endtask

  task automatic test_cnt_wrap;
    logic [1:0]  exp_cnt [5];
    logic [7:0]  b;
    logic [31:0] ea;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    out_ready = 1'b1;
    for (int p = 0; p < 5; p++) begin
      b = 8'h10 * 8'(p) + 8'h01;
      ea = {b, b + 8'd1, b + 8'd2, b + 8'd3};
      stream(b);
      checks++; if (out_a !== ea) begin errors++; $display("FAIL wrap_out_a%0d got=%h want=%h", p, out_a, ea); end
      @(posedge clk); #1;
      checks++; if (frame_cnt2 !== exp_cnt[p]) begin errors++; $display("FAIL wrap_cnt%0d got=%0d want=%0d", p, frame_cnt2, exp_cnt[p]); end
    end
    checks++; if (frame_cnt !== 16'd5) begin errors++; $display("FAIL wrap_cnt16 got=%0d want=5", frame_cnt); end
  endtask

  task automatic test_gapped;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'h01 + 8'(i); in_sof = (i == 0);
      @(posedge clk); #1;
      in_valid = 1'b0; in_sof = 1'b0;
      if (i < 7) begin
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_early_valid%0d got=%b want=0", i, out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got=%b want=1", out_valid); end
    checks++; if (out_a !== 32'h01020304 || out_b !== 32'h05060708) begin errors++; $display("FAIL gap_data got=%h/%h want=01020304/05060708", out_a, out_b); end
    @(posedge clk); #1;
    checks++; if (frame_cnt !== 16'd6 || out_valid !== 1'b0) begin errors++; $display("FAIL gap_cnt got=%0d/%b want=6/0", frame_cnt, out_valid); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_sof_resync;
    test_reset_midframe;
    test_cnt_wrap;
    test_gapped;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
